// File: rtl/myc64_pkg.sv
// Shared types for the C64 .PRG loader.
// Loader FSM states and header length.
package myc64_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_HDR_LO,
    LDR_HDR_HI,
    LDR_DATA,
    LDR_DRAIN,
    LDR_DONE
  } ldr_state_e;

  localparam int PRG_HDR_BYTES = 2;

endpackage

// File: rtl/myc64_sync_fifo.sv
// First-word-fall-through sync FIFO with flush.
// Ports: clk_i, rst_i, flush_i, push_i/din_i, pop_i/dout_o, full_o, empty_o.
module myc64_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/myc64_prg_loader.sv
// Streams a .PRG file (LE load address + payload) into C64 RAM via ext port.
// Ports: byte stream (i_data/i_valid/i_last/o_ready), ext write port, status.
module myc64_prg_loader
  import myc64_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic        o_ext_we,
  output logic [15:0] o_ext_addr,
  output logic [7:0]  o_ext_data,
  input  logic        i_ext_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_end_addr
);

  ldr_state_e  state_q, state_d;
  logic [15:0] wp_q, wp_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] end_q, end_d;
  logic [7:0]  data_q, data_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        drop_q, drop_d;

  logic        f_push, f_pop, f_flush;
  logic        f_full, f_empty;
  logic [7:0]  f_dout;
  logic        rdy, acc, eng;

  myc64_sync_fifo #(
    .DW    (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (f_flush),
    .push_i  (f_push),
    .din_i   (i_data),
    .pop_i   (f_pop),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign eng = (state_q == LDR_DATA) || (state_q == LDR_DRAIN);

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    err_d   = err_q;
    drop_d  = drop_q;
    end_d   = end_q;
    done_d  = 1'b0;
    f_push  = 1'b0;
    f_pop   = 1'b0;
    f_flush = 1'b0;
    rdy     = 1'b0;
    unique case (state_q)
      LDR_IDLE, LDR_DONE: begin
        if (i_start) begin
          state_d = LDR_HDR_LO;
          err_d   = 1'b0;
          drop_d  = 1'b0;
        end
      end
      LDR_HDR_LO: rdy = 1'b1;
      LDR_HDR_HI: rdy = 1'b1;
      LDR_DATA:   rdy = drop_q | ~f_full;
      LDR_DRAIN: begin
        if (f_empty && !we_q) state_d = LDR_DONE;
      end
      default: state_d = LDR_IDLE;
    endcase
    acc = i_valid & rdy;
    if (acc) begin
      unique case (state_q)
        LDR_HDR_LO: begin
          wp_d[7:0] = i_data;
          state_d   = LDR_HDR_HI;
          // A file that ends inside the header is unusable.
          if (i_last) begin
            err_d   = 1'b1;
            wp_d    = '0;
            state_d = LDR_DONE;
          end
        end
        LDR_HDR_HI: begin
          wp_d[15:8] = i_data;
          state_d    = i_last ? LDR_DONE : LDR_DATA;
        end
        LDR_DATA: begin
          f_push = ~drop_q;
          if (i_last) state_d = drop_q ? LDR_DONE : LDR_DRAIN;
        end
        default: ;
      endcase
    end
    if (eng && we_q && i_ext_ready) begin
      wp_d = wp_q + 16'd1;
      we_d = 1'b0;
      // Committed the top byte of RAM with payload still to come:
      // discard everything else and finish with a wrapped pointer.
      if (wp_q == 16'hFFFF &&
          (!f_empty || state_q == LDR_DATA)) begin
        err_d   = 1'b1;
        f_flush = 1'b1;
        f_push  = 1'b0;
        if (state_q == LDR_DRAIN || (acc && i_last))
          state_d = LDR_DONE;
        else
          drop_d = 1'b1;
      end
    end else if (eng && !we_q && !f_empty && !drop_q) begin
      f_pop  = 1'b1;
      addr_d = wp_q;
      data_d = f_dout;
      we_d   = 1'b1;
    end
    if (state_d == LDR_DONE && state_q != LDR_DONE) begin
      done_d = 1'b1;
      end_d  = wp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LDR_IDLE;
      wp_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      end_q   <= end_d;
    end
  end

  assign o_ready    = rdy;
  assign o_ext_we   = we_q;
  assign o_ext_addr = addr_q;
  assign o_ext_data = data_q;
  assign o_busy     = (state_q == LDR_HDR_LO) || (state_q == LDR_HDR_HI) ||
                      (state_q == LDR_DATA)   || (state_q == LDR_DRAIN);
  assign o_done     = done_q;
  assign o_error    = err_q;
  assign o_end_addr = end_q;

endmodule

// File: tb/tb_myc64_prg_loader.sv
// Bench for myc64_prg_loader: table of files plus random files,
// with an 8-clk ext-port model and an arithmetic reference model.
module tb_myc64_prg_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        o_ready;
  logic        o_ext_we;
  logic [15:0] o_ext_addr;
  logic [7:0]  o_ext_data;
  logic        i_ext_ready = 1'b0;
  logic        o_busy, o_done, o_error;
  logic [15:0] o_end_addr;

  myc64_prg_loader #(.FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .o_ext_we    (o_ext_we),
    .o_ext_addr  (o_ext_addr),
    .o_ext_data  (o_ext_data),
    .i_ext_ready (i_ext_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_end_addr  (o_end_addr)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Ext port model: sample on ph2, answer on the following ph1.
  logic [23:0] wlog[$];
  int  phase = 0;
  bit  pend = 0;
  bit  stray = 0;
  int  done_cnt = 0;

  always @(negedge clk) begin
    phase = (phase + 1) % 8;
    i_ext_ready = 1'b0;
    if (o_done) done_cnt++;
    if (rst) begin
      pend = 0;
    end else if (phase == 0 && pend) begin
      i_ext_ready = 1'b1;
      pend = 0;
    end else if (phase == 4 && o_ext_we && !pend) begin
      wlog.push_back({o_ext_addr, o_ext_data});
      pend = 1;
    end else if (stray && !o_ext_we && !pend) begin
      i_ext_ready = 1'b1;
    end
  end

  logic [7:0] pay [64];

  function automatic void prg_model(input logic [15:0] la, input int n,
                                    input bit sh, output int nw,
                                    output logic [15:0] xend,
                                    output bit xerr);
    int top;
    if (sh) begin
      nw = 0; xerr = 1; xend = 16'h0000;
    end else begin
      top = int'(la) + n;
      if (top > 65536) begin
        nw = 65536 - int'(la); xerr = 1;
      end else begin
        nw = n; xerr = 0;
      end
      xend = 16'(int'(la) + nw);
    end
  endfunction

  task automatic fill_pay();
    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
  endtask

  task automatic run_file(input logic [15:0] la, input int n,
                          input bit sh, input bit gaps, input bit inj,
                          input logic [15:0] xend, input bit xerr,
                          input string nm);
    logic [7:0] b[$];
    int idx, cyc, nw;
    logic [15:0] m_end;
    bit m_err, rd, saw_stall;
    prg_model(la, n, sh, nw, m_end, m_err);
    wlog.delete();
    done_cnt = 0;
    stray = inj;
    saw_stall = 0;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk({nm, "_start"}, {30'b0, o_busy, o_error}, 32'h2);
    b.push_back(la[7:0]);
    if (!sh) begin
      b.push_back(la[15:8]);
      for (int i = 0; i < n; i++) b.push_back(pay[i]);
    end
    idx = 0;
    cyc = 0;
    while (idx < b.size() && cyc < 5000) begin
      i_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_data  = b[idx];
      i_last  = (idx == b.size() - 1);
      i_start = inj && (idx == 4);
      @(negedge clk);
      rd = o_ready;
      if (i_valid && !rd) saw_stall = 1;
      @(posedge clk); #1;
      if (i_valid && rd) idx++;
      cyc++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_start = 1'b0;
    chk({nm, "_sent"}, idx, b.size());
    for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
      @(posedge clk); #1;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    stray = 0;
    chk({nm, "_done"}, done_cnt, 1);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_end"}, o_end_addr, xend);
    chk({nm, "_err"}, o_error, xerr);
    chk({nm, "_nwr"}, wlog.size(), nw);
    for (int i = 0; i < nw && i < wlog.size(); i++)
      chk({nm, "_wr"}, {8'h0, wlog[i]},
          {8'h0, 16'(int'(la) + i), pay[i]});
    if (!gaps && n > 18) chk({nm, "_stall"}, saw_stall, 1);
  endtask

  typedef struct {
    logic [15:0] la;
    int          n;
    bit          sh;
    bit          gaps;
    bit          inj;
    logic [15:0] xend;
    bit          xerr;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int nw;
    logic [15:0] la, xe;
    bit xr, sh;
    int n;

    tbl[0] = '{16'hC000, 40, 0, 0, 0, 16'hC028, 0};
    tbl[1] = '{16'hFFFE,  4, 0, 0, 0, 16'h0000, 1};
    tbl[2] = '{16'h0034,  0, 1, 0, 0, 16'h0000, 1};
    tbl[3] = '{16'h1000,  5, 0, 1, 0, 16'h1005, 0};
    tbl[4] = '{16'h1234,  0, 0, 0, 0, 16'h1234, 0};
    tbl[5] = '{16'hFFFF,  1, 0, 0, 0, 16'h0000, 0};
    tbl[6] = '{16'h00FF,  5, 0, 1, 1, 16'h0104, 0};
    tbl[7] = '{16'hFFF0, 20, 0, 1, 0, 16'h0000, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset", {o_ready, o_ext_we, o_ext_addr, o_ext_data, o_busy,
                  o_done, o_error, o_end_addr}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill_pay();
    pay[0] = 8'hA9; pay[1] = 8'h00; pay[2] = 8'h60;
    run_file(16'h0801, 3, 0, 0, 0, 16'h0804, 0, "basic");

    for (int t = 0; t < 8; t++) begin
      fill_pay();
      run_file(tbl[t].la, tbl[t].n, tbl[t].sh, tbl[t].gaps, tbl[t].inj,
               tbl[t].xend, tbl[t].xerr, $sformatf("tbl%0d", t));
    end

    // Reset while a RAM write is outstanding.
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    begin
      int c;
      c = 0;
      while (!o_ext_we && c < 200) begin
        i_valid = 1'b1;
        i_data  = 8'(c + 8'h20);
        i_last  = 1'b0;
        @(posedge clk); #1;
        c++;
      end
      chk("rst_we_seen", o_ext_we, 1);
    end
    rst = 1'b1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid", {o_ready, o_ext_we, o_ext_addr, o_ext_data, o_busy,
                    o_done, o_error, o_end_addr}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    fill_pay();
    run_file(16'h2000, 6, 0, 1, 0, 16'h2006, 0, "after_rst");

    for (int r = 0; r < 8; r++) begin
      fill_pay();
      la = ($urandom_range(0, 2) == 0) ?
           16'(16'hFFFF - $urandom_range(0, 24)) : 16'($urandom);
      n  = $urandom_range(0, 30);
      sh = ($urandom_range(0, 9) == 0);
      prg_model(la, n, sh, nw, xe, xr);
      run_file(la, n, sh, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), xe, xr,
               $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
